instr_stats_profiler: RTL and testbench
=======================================

Name: instr_stats_profiler

Overview:
- Parametrised successor to the single-width MIPS instruction-mix decoder.
- Classifies a stream of 32-bit MIPS instruction words into R/I/J types and counts destination-register writes for all 32 GPRs.
- Adds valid qualification, a 2-stage pipeline, saturate/wrap mode, freeze and clear controls, a sticky overflow flag, and an addressed registered read-out port.
- Sits beside instruction fetch as a non-intrusive profiling monitor.

Parameters:
- CNT_W, 8: width of every counter, including the total counter.
- SATURATE, 1: 1 = counters stick at all-ones; 0 = counters wrap to 0.
- COUNT_R0, 0: 1 = writes naming $0 are counted in register counter 0; 0 = ignored.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- instr_valid  in  1  instr carries a real instruction this cycle.
- instr  in  32  MIPS instruction word.
- clear  in  1  Synchronous clear of all counters and ovf.
- freeze  in  1  Stop sampling; counters hold.
- rd_sel  in  6  Read-out address. 0..31 = reg counters; 32 = R; 33 = I; 34 = J; 35 = total; 36..63 read 0.
- rd_data  out  CNT_W  Registered read-out value.
- ovf  out  1  Sticky: set when any counter saturates or wraps.

Behaviour:
- Reset (async, rst=1): all counters, s1_valid, s1_instr, rd_data and ovf go to 0 immediately and are held until rst deasserts.
- Stage 1 (capture):
  - s1_valid <= instr_valid & ~freeze & ~clear.
  - s1_instr <= instr.
- Stage 2 (count), applied when s1_valid=1:
  - Classification by opcode = s1_instr[31:26]:
    - 0x00 → R type; dest = rd[15:11].
    - 0x02 (j) → J type; no dest.
    - 0x03 (jal) → J type; dest = 31.
    - 0x04, 0x05, 0x06, 0x07 (branches) and 0x28, 0x29, 0x2B (stores) → I type; no dest.
    - Any other opcode → I type; dest = rt[20:16].
  - Updates:
    - Type counter += 1.
    - Total += 1.
    - Counter for dest += 1, if a dest exists and (dest != 0 or COUNT_R0=1).
  - At most one type counter and one reg counter change per cycle.
- Arithmetic:
  - All counters are CNT_W unsigned.
  - At all-ones with SATURATE=1: hold at all-ones and set ovf.
  - At all-ones with SATURATE=0: wrap to 0 and set ovf.
  - ovf clears only on rst or clear.
- Latency: instruction sampled at edge N → counters updated at edge N+1 → visible on rd_data after edge N+2 (if rd_sel is stable).
- Read-out: rd_data <= mux(rd_sel) every cycle, whether or not freeze is asserted.
- clear:
  - At the edge where clear=1, all counters and ovf become 0.
  - clear has priority over a simultaneous stage-2 increment, which is discarded.
  - An instruction presented alongside clear is not captured.
  - The first counted instruction is one presented at or after the edge following clear deassertion.
- freeze:
  - New instructions are not captured.
  - An instruction already in stage 1 still completes its count.
  - Read-out keeps working.
- clear and freeze together: clear wins for counters; nothing is captured.
- Reset asserted mid-stream: any in-flight stage-1 instruction is lost; counting restarts from 0.

Decomposition:
- Shared package instr_stats_pkg:
  - Opcode constants (OP_RTYPE, OP_J, OP_JAL, branch and store opcodes).
  - Read-out address constants (SEL_R=32, SEL_I=33, SEL_J=34, SEL_TOT=35).
  - Enum instr_kind_t {KIND_R, KIND_I, KIND_J}.
- Sub-module instr_classify (combinational). Input: instr. Outputs: kind, has_dest, dest[4:0].
- instr_classify is instantiated at stage 2 and unit-tested separately.

Test Plan:
- Reset, then send add $3,$1,$2 (0x00221820), addi $4,$0,5 (0x20040005), jal (0x0C000000):
  - rd_sel 3 → 1; rd_sel 4 → 1; rd_sel 31 → 1.
  - R=1, I=1, J=1, total=3.
- sw $5,0($1) (0xAC250000), then beq $6,$6 (0x10C60000):
  - I=2, total=2.
  - Reg counters 5 and 6 stay 0.
- CNT_W=3, SATURATE=1, 9 consecutive add $3:
  - Reg 3 = 7, R = 7, ovf=1.
  - Repeat with SATURATE=0: reg 3 = 1, ovf=1.
- Two valid instructions with clear asserted in the cycle the second is in stage 1:
  - All counters 0 and ovf=0 afterwards.
  - The next add $4 gives reg 4 = 1.
- freeze=1 for 4 valid instructions, with one instruction already in stage 1 when freeze rises:
  - total increases by exactly 1.
  - Reading rd_sel=35 during freeze returns that value.
- rst pulse mid-stream, asynchronous and not aligned to clk:
  - rd_data and ovf are 0 before the next clock edge.
  - Counts resume correctly after rst deasserts.

Source files
------------

// File: rtl/instr_stats_pkg.sv
// Shared constants and types for the instruction-mix profiler.
// Opcode values, read-out addresses and the instruction kind enum.
package instr_stats_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] SEL_R   = 6'd32;
    localparam logic [5:0] SEL_I   = 6'd33;
    localparam logic [5:0] SEL_J   = 6'd34;
    localparam logic [5:0] SEL_TOT = 6'd35;

    localparam int NUM_GPR = 32;

    typedef enum logic [1:0] {KIND_R, KIND_I, KIND_J} instr_kind_t;

endpackage

// File: rtl/instr_stats_profiler_classify.sv
// Combinational MIPS instruction classifier: R/I/J kind and the GPR it writes.
module instr_classify
    import instr_stats_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_kind_t  kind,
    output logic         has_dest,
    output logic [4:0]   dest
);

    logic [5:0] opcode;
    logic       unused_bits;

    assign opcode      = instr[31:26];
    assign unused_bits = ^{instr[25:21], instr[10:0]};

    always_comb begin
        kind     = KIND_I;
        has_dest = 1'b1;
        dest     = instr[20:16];
        case (opcode)
            OP_RTYPE: begin
                kind = KIND_R;
                dest = instr[15:11];
            end
            OP_J: begin
                kind     = KIND_J;
                has_dest = 1'b0;
                dest     = 5'd0;
            end
            OP_JAL: begin
                kind = KIND_J;
                dest = 5'd31;
            end
            // branches and stores read rt but never write it
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_SB, OP_SH, OP_SW: begin
                has_dest = 1'b0;
                dest     = 5'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_stats_profiler.sv
// Non-intrusive instruction-mix profiler: capture stage, count stage and a
// registered read-out port over the per-GPR, per-kind and total counters.
module instr_stats_profiler
    import instr_stats_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1,
    parameter bit COUNT_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    input  logic             clear,
    input  logic             freeze,
    input  logic [5:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_instr_q;
    logic [CNT_W-1:0] reg_cnt_q [NUM_GPR];
    logic [CNT_W-1:0] reg_cnt_d [NUM_GPR];
    logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
    logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0] j_cnt_q, j_cnt_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    instr_kind_t      s2_kind;
    logic             s2_has_dest;
    logic [4:0]       s2_dest;
    logic             count_dest;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX)
            return SATURATE ? CNT_MAX : '0;
        return v + CNT_W'(1);
    endfunction

    instr_classify u_classify (
        .instr    (s1_instr_q),
        .kind     (s2_kind),
        .has_dest (s2_has_dest),
        .dest     (s2_dest)
    );

    assign count_dest = s2_has_dest && ((s2_dest != 5'd0) || COUNT_R0);
    assign s1_valid_d = instr_valid & ~freeze & ~clear;

    always_comb begin
        reg_cnt_d = reg_cnt_q;
        r_cnt_d   = r_cnt_q;
        i_cnt_d   = i_cnt_q;
        j_cnt_d   = j_cnt_q;
        tot_d     = tot_q;
        ovf_d     = ovf_q;
        if (clear) begin
            for (int g = 0; g < NUM_GPR; g++)
                reg_cnt_d[g] = '0;
            r_cnt_d = '0;
            i_cnt_d = '0;
            j_cnt_d = '0;
            tot_d   = '0;
            ovf_d   = 1'b0;
        end else if (s1_valid_q) begin
            tot_d = bump(tot_q);
            ovf_d = ovf_d | (tot_q == CNT_MAX);
            case (s2_kind)
                KIND_R: begin
                    r_cnt_d = bump(r_cnt_q);
                    ovf_d   = ovf_d | (r_cnt_q == CNT_MAX);
                end
                KIND_I: begin
                    i_cnt_d = bump(i_cnt_q);
                    ovf_d   = ovf_d | (i_cnt_q == CNT_MAX);
                end
                default: begin
                    j_cnt_d = bump(j_cnt_q);
                    ovf_d   = ovf_d | (j_cnt_q == CNT_MAX);
                end
            endcase
            if (count_dest) begin
                reg_cnt_d[s2_dest] = bump(reg_cnt_q[s2_dest]);
                ovf_d              = ovf_d | (reg_cnt_q[s2_dest] == CNT_MAX);
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        case (rd_sel)
            SEL_R:   rd_data_d = r_cnt_q;
            SEL_I:   rd_data_d = i_cnt_q;
            SEL_J:   rd_data_d = j_cnt_q;
            SEL_TOT: rd_data_d = tot_q;
            default: if (!rd_sel[5]) rd_data_d = reg_cnt_q[rd_sel[4:0]];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            for (int g = 0; g < NUM_GPR; g++)
                reg_cnt_q[g] <= '0;
            r_cnt_q    <= '0;
            i_cnt_q    <= '0;
            j_cnt_q    <= '0;
            tot_q      <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_instr_q <= instr;
            for (int g = 0; g < NUM_GPR; g++)
                reg_cnt_q[g] <= reg_cnt_d[g];
            r_cnt_q    <= r_cnt_d;
            i_cnt_q    <= i_cnt_d;
            j_cnt_q    <= j_cnt_d;
            tot_q      <= tot_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_instr_stats_profiler.sv
// Directed bench for instr_stats_profiler: three configurations share one
// stimulus stream and are checked every cycle against a true-count model.
module tb_instr_stats_profiler;
    import instr_stats_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        clear = 1'b0;
    logic        freeze = 1'b0;
    logic [5:0]  rd_sel = '0;

    logic [7:0]  rd_a;
    logic [2:0]  rd_s, rd_w;
    logic        ovf_a, ovf_s, ovf_w;

    logic [31:0] c_instr;
    instr_kind_t c_kind;
    logic        c_has;
    logic [4:0]  c_dest;

    always #5 clk = ~clk;

    instr_stats_profiler #(.CNT_W(8), .SATURATE(1'b1), .COUNT_R0(1'b0)) dut_a (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .clear(clear),
        .freeze(freeze), .rd_sel(rd_sel), .rd_data(rd_a), .ovf(ovf_a));
    instr_stats_profiler #(.CNT_W(3), .SATURATE(1'b1), .COUNT_R0(1'b0)) dut_s (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .clear(clear),
        .freeze(freeze), .rd_sel(rd_sel), .rd_data(rd_s), .ovf(ovf_s));
    instr_stats_profiler #(.CNT_W(3), .SATURATE(1'b0), .COUNT_R0(1'b1)) dut_w (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .clear(clear),
        .freeze(freeze), .rd_sel(rd_sel), .rd_data(rd_w), .ovf(ovf_w));

    instr_classify u_cls (.instr(c_instr), .kind(c_kind), .has_dest(c_has), .dest(c_dest));

    // Model: unbounded true counts since the last clear/reset; the visible
    // counter value and ovf are derived from them per configuration.
    int cw   [3] = '{8, 3, 3};
    bit csat [3] = '{1'b1, 1'b1, 1'b0};
    bit cr0  [3] = '{1'b0, 1'b0, 1'b1};
    int cnt  [3][36];
    bit          m_s1_valid;
    logic [31:0] m_s1_instr;
    int exp_rd  [3];
    bit exp_ovf [3];
    int nvec = 0;
    int nfail = 0;

    function automatic void classify_m(input logic [31:0] w, output int kind,
                                       output bit has, output int dest);
        kind = 1; has = 1'b1; dest = int'(w[20:16]);
        case (w[31:26])
            6'h00: begin kind = 0; dest = int'(w[15:11]); end
            6'h02: begin kind = 2; has = 1'b0; dest = 0; end
            6'h03: begin kind = 2; dest = 31; end
            6'h04, 6'h05, 6'h06, 6'h07, 6'h28, 6'h29, 6'h2B: begin has = 1'b0; dest = 0; end
            default: ;
        endcase
    endfunction

    function automatic int view(input int k, input int sel);
        int mx, c;
        if (sel > 35) return 0;
        mx = (1 << cw[k]) - 1;
        c  = cnt[k][sel];
        if (csat[k]) return (c > mx) ? mx : c;
        return c % (mx + 1);
    endfunction

    task automatic zero_model();
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < 36; s++)
                cnt[k][s] = 0;
    endtask

    task automatic model_edge();
        int kind, dest;
        bit has;
        for (int k = 0; k < 3; k++) exp_rd[k] = view(k, int'(rd_sel));
        if (rst) begin
            zero_model();
            m_s1_valid = 1'b0;
            for (int k = 0; k < 3; k++) exp_rd[k] = 0;
        end else begin
            if (clear) zero_model();
            else if (m_s1_valid) begin
                classify_m(m_s1_instr, kind, has, dest);
                for (int k = 0; k < 3; k++) begin
                    cnt[k][32 + kind]++;
                    cnt[k][35]++;
                    if (has && (dest != 0 || cr0[k])) cnt[k][dest]++;
                end
            end
            m_s1_valid = instr_valid & ~freeze & ~clear;
            m_s1_instr = instr;
        end
        for (int k = 0; k < 3; k++) begin
            exp_ovf[k] = 1'b0;
            for (int s = 0; s < 36; s++)
                if (cnt[k][s] > (1 << cw[k]) - 1) exp_ovf[k] = 1'b1;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("rd_a", int'(rd_a), exp_rd[0]);
        check("rd_s", int'(rd_s), exp_rd[1]);
        check("rd_w", int'(rd_w), exp_rd[2]);
        check("ovf_a", int'(ovf_a), int'(exp_ovf[0]));
        check("ovf_s", int'(ovf_s), int'(exp_ovf[1]));
        check("ovf_w", int'(ovf_w), int'(exp_ovf[2]));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [31:0] w);
        instr_valid = 1'b1;
        instr = w;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic read(input int sel);
        rd_sel = 6'(sel);
        tick();
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    localparam logic [31:0] ADD3 = 32'h0022_1820;
    localparam logic [31:0] ADD4 = 32'h0022_2020;
    localparam logic [31:0] ADD5 = 32'h0022_2820;
    localparam logic [31:0] ADD6 = 32'h0022_3020;

    logic [31:0] cls_vec [12] = '{32'h0022_1820, 32'h2004_0005, 32'h0800_0000, 32'h0C00_0000,
                                 32'h10C6_0000, 32'h1400_0000, 32'h1800_0000, 32'h1C00_0000,
                                 32'hA000_0000, 32'hA400_0000, 32'hAC25_0000, 32'h8C25_0000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int kind, dest;
        bit has;
        zero_model();
        m_s1_valid = 1'b0;
        m_s1_instr = '0;

        for (int i = 0; i < 12; i++) begin
            c_instr = cls_vec[i];
            #1;
            classify_m(cls_vec[i], kind, has, dest);
            check("cls_kind", int'(c_kind), kind);
            check("cls_has", int'(c_has), int'(has));
            check("cls_dest", int'(c_dest), dest);
        end
        c_instr = 32'h8C25_0000;
        #1;
        check("cls_lw_dest_lit", int'(c_dest), 5);

        tick(); tick();
        rst = 1'b0;
        check("reset_rd_lit", int'(rd_a), 0);
        check("reset_ovf_lit", int'(ovf_a), 0);

        // add / addi / jal
        send(ADD3); send(32'h2004_0005); send(32'h0C00_0000);
        idle(2);
        read(3);  check("t1_reg3_lit", int'(rd_a), 1);
        read(4);  check("t1_reg4_lit", int'(rd_a), 1);
        read(31); check("t1_reg31_lit", int'(rd_a), 1);
        read(32); check("t1_R_lit", int'(rd_a), 1);
        read(33); check("t1_I_lit", int'(rd_a), 1);
        read(34); check("t1_J_lit", int'(rd_a), 1);
        read(35); check("t1_tot_lit", int'(rd_a), 3);

        // store and branch: I-type, no destination
        clear_pulse();
        send(32'hAC25_0000); send(32'h10C6_0000);
        idle(2);
        read(33); check("t2_I_lit", int'(rd_a), 2);
        read(35); check("t2_tot_lit", int'(rd_a), 2);
        read(5);  check("t2_reg5_lit", int'(rd_a), 0);
        read(6);  check("t2_reg6_lit", int'(rd_a), 0);
        send(32'h0000_0020);
        idle(2);
        read(0);  check("r0_ignored_lit", int'(rd_a), 0);
                  check("r0_counted_lit", int'(rd_w), 1);
        read(63); check("sel63_lit", int'(rd_a), 0);

        // saturate vs wrap with 3-bit counters
        clear_pulse();
        instr_valid = 1'b1;
        instr = ADD3;
        for (int i = 0; i < 9; i++) tick();
        idle(2);
        read(3);  check("sat_reg3_lit", int'(rd_s), 7);
                  check("wrap_reg3_lit", int'(rd_w), 1);
                  check("wide_reg3_lit", int'(rd_a), 9);
        read(32); check("sat_R_lit", int'(rd_s), 7);
        check("sat_ovf_lit", int'(ovf_s), 1);
        check("wrap_ovf_lit", int'(ovf_w), 1);
        check("wide_ovf_lit", int'(ovf_a), 0);

        // clear while the second instruction sits in stage 1
        rd_sel = 6'd35;
        instr_valid = 1'b1;
        instr = ADD3; tick();
        instr = ADD5; tick();
        instr = ADD6; clear = 1'b1; tick();
        clear = 1'b0;
        idle(2);
        check("clr_tot_lit", int'(rd_a), 0);
        check("clr_ovf_s_lit", int'(ovf_s), 0);
        check("clr_ovf_w_lit", int'(ovf_w), 0);
        send(ADD4);
        idle(2);
        read(4);  check("clr_reg4_lit", int'(rd_a), 1);
        read(35); check("clr_tot1_lit", int'(rd_a), 1);

        // freeze with one instruction already in stage 1
        instr_valid = 1'b1;
        instr = ADD3; tick();
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = (i % 2 == 0) ? ADD5 : 32'h2004_0005;
            tick();
        end
        instr_valid = 1'b0;
        tick();
        check("frz_tot_lit", int'(rd_a), 2);
        freeze = 1'b0;
        idle(2);
        check("frz_after_lit", int'(rd_a), 2);

        // asynchronous reset mid-stream
        send(ADD3);
        check("pre_rst_lit", int'(rd_a), 2);
        #3 rst = 1'b1;
        #1;
        zero_model();
        m_s1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin exp_rd[k] = 0; exp_ovf[k] = 1'b0; end
        check("arst_rd_lit", int'(rd_a), 0);
        compare_all();
        tick();
        #2 rst = 1'b0;
        send(ADD4);
        idle(2);
        read(4);  check("rst_reg4_lit", int'(rd_a), 1);
        read(3);  check("rst_reg3_lit", int'(rd_a), 0);
        read(35); check("rst_tot_lit", int'(rd_a), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
